// File: rtl/pattern_sched_pkg.sv
// Shared constants for the pattern scheduler: FSM encodings, widths, record sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pattern_sched_pkg;

  // Scheduler FSM encodings (kept as plain constants for older consumers)
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Default field widths of a stimulus record
  localparam int TIME_W_DEF = 32;
  localparam int BIN_W_DEF  = 4;
  localparam int DEC_W_DEF  = 32;
  localparam int HEX_W_DEF  = 32;

  // Stored record width: {time, bin, dec, hex}
  localparam int REC_W = TIME_W_DEF + BIN_W_DEF + DEC_W_DEF + HEX_W_DEF;

  // Width of the saturating dropped-record counter
  localparam int ERR_W = 8;

  // Record width for non-default field widths
  function automatic int rec_width(input int tw, input int bw, input int dw, input int hw);
    return tw + bw + dw + hw;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with full/empty/count and a synchronous flush.
// Latency: a word written at edge N is visible on rd_dat from cycle N+1 (show-ahead).
// Backpressure: writes while full and reads while empty are ignored; full is the producer's stall.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_vld,
  input  logic [WIDTH-1:0]         wr_dat,
  input  logic                     rd_rdy,
  output logic [WIDTH-1:0]         rd_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_wr;
  logic             do_rd;

  assign do_wr  = wr_vld && !full;
  assign do_rd  = rd_rdy && !empty;
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign empty  = (cnt == '0);
  assign count  = cnt;
  assign rd_dat = mem[rptr];

  // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_wr) wptr <= wptr + AW'(1);
      if (do_rd) rptr <= rptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage array; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_dat;
  end

endmodule

// File: rtl/pattern_scheduler.sv
// Buffers timestamped stimulus records and applies each payload when the cycle counter reaches its time.
// Latency: record at FIFO head from cycle after acceptance; out_* / out_strobe one cycle after head.time <= now.
// Backpressure: rec_ready drops while the FIFO is full or once the final record has been taken.
module pattern_scheduler
  import pattern_sched_pkg::*;
#(
  parameter int TIME_W = TIME_W_DEF,
  parameter int DEPTH  = 4,
  parameter int BIN_W  = BIN_W_DEF,
  parameter int DEC_W  = DEC_W_DEF,
  parameter int HEX_W  = HEX_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rec_valid,
  output logic              rec_ready,
  input  logic              rec_comment,
  input  logic              rec_last,
  input  logic [TIME_W-1:0] rec_time,
  input  logic [BIN_W-1:0]  rec_bin,
  input  logic [DEC_W-1:0]  rec_dec,
  input  logic [HEX_W-1:0]  rec_hex,
  output logic [BIN_W-1:0]  out_bin,
  output logic [DEC_W-1:0]  out_dec,
  output logic [HEX_W-1:0]  out_hex,
  output logic              out_strobe,
  output logic              err_order,
  output logic [ERR_W-1:0]  err_count,
  output logic [TIME_W-1:0] now,
  output logic              busy,
  output logic              done
);

  localparam int RW = rec_width(TIME_W, BIN_W, DEC_W, HEX_W);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]        state;
  logic              last_seen;
  logic [TIME_W-1:0] last_time;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_cnt;
  logic [RW-1:0]     fifo_wr_dat;
  logic [RW-1:0]     head;

  logic [TIME_W-1:0] head_time;
  logic [BIN_W-1:0]  head_bin;
  logic [DEC_W-1:0]  head_dec;
  logic [HEX_W-1:0]  head_hex;

  logic              accept;
  logic              fifo_wr;
  logic              restart;
  logic              go;
  logic              pop;
  logic              head_late;
  logic              drained;

  // Record layout in the FIFO: {time, bin, dec, hex}
  assign fifo_wr_dat = {rec_time, rec_bin, rec_dec, rec_hex};
  assign head_time   = head[RW-1 -: TIME_W];
  assign head_bin    = head[DEC_W+HEX_W +: BIN_W];
  assign head_dec    = head[HEX_W +: DEC_W];
  assign head_hex    = head[HEX_W-1:0];

  // Ready ignores a same-cycle pop so the producer sees a registered-only dependency
  assign rec_ready = rst_n && !fifo_full && !last_seen;
  assign accept    = rec_valid && rec_ready;
  assign fifo_wr   = accept && !rec_comment;

  // start re-arms only from DONE (flush) or launches from IDLE (keeps preloaded records)
  assign restart   = start && (state == ST_DONE);
  assign go        = start && ((state == ST_IDLE) || (state == ST_DONE));

  // One head decision per cycle while running; late-but-ordered records still apply
  assign pop       = (state == ST_RUN) && !fifo_empty && (head_time <= now);
  assign head_late = (head_time < last_time);

  // No writes are possible once last_seen is set, so the FIFO only drains from here
  assign drained   = last_seen && (fifo_empty || ((fifo_cnt == CW'(1)) && pop));

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .flush  (restart),
    .wr_vld (fifo_wr),
    .wr_dat (fifo_wr_dat),
    .rd_rdy (pop),
    .rd_dat (head),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .count  (fifo_cnt)
  );

  // Control FSM: IDLE -> RUN on start, RUN -> DONE when the final record has left the FIFO
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start)   state <= ST_RUN;
        ST_RUN:  if (drained) state <= ST_DONE;
        ST_DONE: if (start)   state <= ST_RUN;
        default:              state <= ST_IDLE;
      endcase
    end
  end

  // Cycle-time counter: zero on (re)start, saturating count in RUN, frozen in DONE
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      now <= '0;
    end else if (go) begin
      now <= '0;
    end else if ((state == ST_RUN) && (now != '1)) begin
      now <= now + TIME_W'(1);
    end
  end

  // Remember that the producer has delivered its final record, comment or not
  always_ff @(posedge clk) begin
    if (!rst_n || restart) begin
      last_seen <= 1'b0;
    end else if (accept && rec_last) begin
      last_seen <= 1'b1;
    end
  end

  // Apply or drop the head record, tracking the last applied timestamp and the error tally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_bin    <= '0;
      out_dec    <= '0;
      out_hex    <= '0;
      out_strobe <= 1'b0;
      err_order  <= 1'b0;
      err_count  <= '0;
      last_time  <= '0;
    end else begin
      out_strobe <= 1'b0;
      err_order  <= 1'b0;
      if (restart) begin
        last_time <= '0;
        err_count <= '0;
      end else if (pop) begin
        if (head_late) begin
          err_order <= 1'b1;
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
        end else begin
          out_bin    <= head_bin;
          out_dec    <= head_dec;
          out_hex    <= head_hex;
          out_strobe <= 1'b1;
          last_time  <= head_time;
        end
      end
    end
  end

endmodule

// File: tb/tb_pattern_scheduler.sv
// Self-checking bench for pattern_scheduler: directed tables, corner sequences, random stream.
// Latency: n/a.
// Backpressure: the push task waits on rec_ready with a bounded retry count.
module tb_pattern_scheduler;
  import pattern_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        rec_valid = 1'b0;
  logic        rec_ready;
  logic        rec_comment = 1'b0;
  logic        rec_last = 1'b0;
  logic [31:0] rec_time = '0;
  logic [3:0]  rec_bin = '0;
  logic [31:0] rec_dec = '0;
  logic [31:0] rec_hex = '0;
  logic [3:0]  out_bin;
  logic [31:0] out_dec;
  logic [31:0] out_hex;
  logic        out_strobe;
  logic        err_order;
  logic [7:0]  err_count;
  logic [31:0] now;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  pattern_scheduler #(.TIME_W(32), .DEPTH(4), .BIN_W(4), .DEC_W(32), .HEX_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .rec_valid(rec_valid), .rec_ready(rec_ready), .rec_comment(rec_comment), .rec_last(rec_last),
    .rec_time(rec_time), .rec_bin(rec_bin), .rec_dec(rec_dec), .rec_hex(rec_hex),
    .out_bin(out_bin), .out_dec(out_dec), .out_hex(out_hex), .out_strobe(out_strobe),
    .err_order(err_order), .err_count(err_count), .now(now), .busy(busy), .done(done)
  );

  typedef struct {
    logic [31:0] t; logic [3:0] b; logic [31:0] d; logic [31:0] h;
    bit cm; bit last; int exp_now;
  } vec_t;

  typedef struct {
    bit is_err; logic [31:0] t; logic [3:0] b; logic [31:0] d; logic [31:0] h; int exp_now;
  } ev_t;

  vec_t        vt [19];
  ev_t         expq [$];
  int          total = 0;
  int          bad = 0;
  int          n_strobe = 0;
  int          base;
  logic [31:0] m_order_last;
  int          m_err;
  logic [3:0]  m_bin;
  logic [31:0] m_dec, m_hex;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic model_clear();
    expq.delete();
    m_order_last = '0;
    m_err = 0;
    m_bin = '0; m_dec = '0; m_hex = '0;
  endtask

  // Scoreboard: every strobe / err pulse consumes the next expected event in FIFO order
  task automatic monitor();
    ev_t e;
    if (out_strobe) begin
      n_strobe++;
      if (expq.size() == 0) fail_now("unexpected_strobe");
      else begin
        e = expq.pop_front();
        chk("strobe_kind", 32'(e.is_err), 32'd0);
        chk("strobe_bin", 32'(out_bin), 32'(e.b));
        chk("strobe_dec", out_dec, e.d);
        chk("strobe_hex", out_hex, e.h);
        chk("strobe_after_time", 32'(now > e.t), 32'd1);
        if (e.exp_now >= 0) chk("strobe_now", now, 32'(e.exp_now));
        m_bin = e.b; m_dec = e.d; m_hex = e.h;
      end
    end
    if (err_order) begin
      if (expq.size() == 0) fail_now("unexpected_err");
      else begin
        e = expq.pop_front();
        chk("err_kind", 32'(e.is_err), 32'd1);
        m_err++;
        chk("err_count", 32'(err_count), 32'((m_err > 255) ? 255 : m_err));
        chk("err_hold_bin", 32'(out_bin), 32'(m_bin));
        chk("err_hold_dec", out_dec, m_dec);
        chk("err_hold_hex", out_hex, m_hex);
        if (e.exp_now >= 0) chk("err_now", now, 32'(e.exp_now));
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    monitor();
  endtask

  task automatic push(input logic [31:0] t, input logic [3:0] b, input logic [31:0] d,
                      input logic [31:0] h, input bit cm, input bit last, input int exp_now);
    bit hs = 1'b0;
    int tries = 0;
    ev_t e;
    rec_valid = 1'b1; rec_time = t; rec_bin = b; rec_dec = d; rec_hex = h;
    rec_comment = cm; rec_last = last;
    while (!hs) begin
      #1;
      hs = rec_ready;
      if (hs && !cm) begin
        e.is_err = (t < m_order_last);
        if (!e.is_err) m_order_last = t;
        e.t = t; e.b = b; e.d = d; e.h = h; e.exp_now = exp_now;
        expq.push_back(e);
      end
      cyc();
      tries++;
      if (!hs && tries > 300) begin
        fail_now("push_timeout");
        break;
      end
    end
    rec_valid = 1'b0; rec_comment = 1'b0; rec_last = 1'b0;
  endtask

  task automatic apply_table(input int lo, input int hi);
    for (int i = lo; i <= hi; i++)
      push(vt[i].t, vt[i].b, vt[i].d, vt[i].h, vt[i].cm, vt[i].last, vt[i].exp_now);
  endtask

  task automatic pulse_start(input bit from_done);
    if (from_done) begin
      m_order_last = '0;
      m_err = 0;
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc();
    model_clear();
    chk("rst_out_bin", 32'(out_bin), 32'd0);
    chk("rst_out_dec", out_dec, 32'd0);
    chk("rst_out_hex", out_hex, 32'd0);
    chk("rst_strobe", 32'(out_strobe), 32'd0);
    chk("rst_err_order", 32'(err_order), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_now", now, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ready_low", 32'(rec_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready_release", 32'(rec_ready), 32'd1);
  endtask

  task automatic run_until_strobes(input int n, input int budget);
    int c = 0;
    while (n_strobe < n && c < budget) begin cyc(); c++; end
    chk("strobes_reached", 32'(n_strobe >= n), 32'd1);
  endtask

  task automatic run_until_done(input int budget);
    int c = 0;
    while (!done && c < budget) begin cyc(); c++; end
    chk("done_reached", 32'(done), 32'd1);
    chk("queue_drained", 32'(expq.size()), 32'd0);
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [31:0] gen;
    logic [31:0] tt;
    bit          cm;

    // Directed vectors: {time, bin, dec, hex, comment, last, expected now at strobe/err (-1: any)}
    vt[0]  = '{t:0,  b:4'h1, d:32'd11,   h:32'hA1, cm:0, last:0, exp_now:1};
    vt[1]  = '{t:5,  b:4'h2, d:32'd22,   h:32'hB2, cm:0, last:0, exp_now:6};
    vt[2]  = '{t:5,  b:4'h3, d:32'd33,   h:32'hC3, cm:0, last:0, exp_now:7};
    vt[3]  = '{t:9,  b:4'h4, d:32'd44,   h:32'hD4, cm:0, last:1, exp_now:10};
    vt[4]  = '{t:10, b:4'h5, d:32'd1000, h:32'hE5, cm:0, last:0, exp_now:11};
    vt[5]  = '{t:4,  b:4'h6, d:32'd2000, h:32'hF6, cm:0, last:1, exp_now:12};
    vt[6]  = '{t:0,  b:4'h7, d:32'd70,   h:32'h107, cm:0, last:0, exp_now:-1};
    vt[7]  = '{t:0,  b:4'h8, d:32'd80,   h:32'h108, cm:0, last:0, exp_now:-1};
    vt[8]  = '{t:1,  b:4'h9, d:32'd90,   h:32'h109, cm:0, last:0, exp_now:-1};
    vt[9]  = '{t:2,  b:4'hA, d:32'd100,  h:32'h10A, cm:0, last:0, exp_now:-1};
    vt[10] = '{t:3,  b:4'hB, d:32'd110,  h:32'h10B, cm:0, last:0, exp_now:-1};
    vt[11] = '{t:4,  b:4'hC, d:32'd120,  h:32'h10C, cm:0, last:1, exp_now:-1};
    vt[12] = '{t:1,  b:4'hD, d:32'd130,  h:32'h10D, cm:0, last:0, exp_now:2};
    vt[13] = '{t:3,  b:4'hE, d:32'd140,  h:32'h10E, cm:0, last:0, exp_now:4};
    vt[14] = '{t:0,  b:4'hF, d:32'hDEAD, h:32'hBEEF, cm:1, last:1, exp_now:-1};
    vt[15] = '{t:0,  b:4'h3, d:32'd555,  h:32'h555, cm:0, last:0, exp_now:1};
    vt[16] = '{t:50, b:4'h1, d:32'd1,    h:32'h1,   cm:0, last:0, exp_now:-1};
    vt[17] = '{t:60, b:4'h2, d:32'd2,    h:32'h2,   cm:0, last:0, exp_now:-1};
    vt[18] = '{t:70, b:4'h3, d:32'd3,    h:32'h3,   cm:0, last:0, exp_now:-1};

    // Preload in IDLE, then run: strobes at now=1,6,7,10; done together with the last strobe
    do_reset();
    apply_table(0, 3);
    chk("idle_now_held", now, 32'd0);
    chk("idle_not_busy", 32'(busy), 32'd0);
    pulse_start(1'b0);
    chk("start_now_zero", now, 32'd0);
    chk("start_busy", 32'(busy), 32'd1);
    base = n_strobe;
    run_until_strobes(base + 3, 40);
    chk("t1_done_before_last", 32'(done), 32'd0);
    run_until_strobes(base + 4, 40);
    chk("t1_done_with_last", 32'(done), 32'd1);
    chk("t1_busy_fell", 32'(busy), 32'd0);
    chk("t1_now_at_done", now, 32'd10);
    repeat (3) cyc();
    chk("t1_now_frozen", now, 32'd10);

    // Out-of-order drop, then restart from DONE clears counters and flushes
    do_reset();
    apply_table(4, 5);
    pulse_start(1'b0);
    run_until_done(60);
    chk("t2_err_count", 32'(err_count), 32'd1);
    chk("t2_out_dec_kept", out_dec, vt[4].d);
    pulse_start(1'b1);
    chk("restart_now", now, 32'd0);
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_err_clr", 32'(err_count), 32'd0);
    chk("restart_ready", 32'(rec_ready), 32'd1);

    // Six records through a depth-4 FIFO; full-plus-pop keeps ready low
    do_reset();
    apply_table(6, 9);
    chk("t3_full_ready", 32'(rec_ready), 32'd0);
    pulse_start(1'b0);
    chk("t3_full_pop_ready", 32'(rec_ready), 32'd0);
    base = n_strobe;
    apply_table(10, 11);
    run_until_done(60);
    chk("t3_strobe_total", 32'(n_strobe - base), 32'd6);

    // Comment carrying rec_last: never applied, closes the input
    do_reset();
    base = n_strobe;
    apply_table(12, 14);
    chk("t4_ready_after_last", 32'(rec_ready), 32'd0);
    pulse_start(1'b0);
    run_until_done(60);
    chk("t4_strobe_total", 32'(n_strobe - base), 32'd2);
    chk("t4_no_err", 32'(err_count), 32'd0);

    // Reset mid-RUN with three records still buffered
    do_reset();
    apply_table(15, 18);
    pulse_start(1'b0);
    base = n_strobe;
    run_until_strobes(base + 1, 20);
    cyc();
    do_reset();
    base = n_strobe;
    repeat (5) cyc();
    chk("t5_idle_now", now, 32'd0);
    pulse_start(1'b0);
    repeat (100) cyc();
    chk("t5_no_stale_strobes", 32'(n_strobe - base), 32'd0);

    // 300 out-of-order records saturate err_count
    do_reset();
    pulse_start(1'b0);
    push(32'd20, 4'h9, 32'd99, 32'h99, 1'b0, 1'b0, 21);
    for (int i = 0; i < 300; i++)
      push($urandom_range(0, 19), 4'(i), 32'(i), 32'(i), 1'b0, (i == 299), -1);
    run_until_done(400);
    chk("t6_err_saturated", 32'(err_count), 32'd255);

    // Randomized stream with gaps, comments and occasional backward timestamps
    do_reset();
    pulse_start(1'b0);
    gen = '0;
    for (int i = 0; i < 80; i++) begin
      repeat ($urandom_range(0, 2)) cyc();
      gen = gen + 32'($urandom_range(0, 4));
      tt = gen;
      if ($urandom_range(0, 5) == 0 && gen > 32'd5) tt = gen - 32'($urandom_range(1, 5));
      cm = ($urandom_range(0, 7) == 0);
      push(tt, 4'($urandom), $urandom, $urandom, cm, (i == 79), -1);
    end
    run_until_done(2000);
    chk("rand_err_count", 32'(err_count), 32'((m_err > 255) ? 255 : m_err));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pattern_scheduler.md
# pattern_scheduler

Synthesizable timed-stimulus scheduler for the fileio pattern flow. A producer (file reader, ROM loader, or bench driver) pushes timestamped stimulus records (time, 4-bit bin, 32-bit dec, 32-bit hex) over a valid/ready port. The block buffers them and applies each payload to registered outputs when an internal cycle-time counter reaches the record's timestamp. Comment records are discarded. Out-of-order timestamps are flagged and dropped.

## Interface
- TIME_W, 32, width of timestamps and time counter
- DEPTH, 4, record FIFO depth (power of two, ≥2)
- BIN_W / DEC_W / HEX_W, 4 / 32 / 32, payload field widths
- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  one-cycle pulse; honoured only in IDLE or DONE
- rec_valid  in  1  producer record valid
- rec_ready  out  1  scheduler can accept
- rec_comment  in  1  record is a comment; consume and discard
- rec_last  in  1  final record of pattern
- rec_time  in  TIME_W  absolute apply time, in cycles after start
- rec_bin / rec_dec / rec_hex  in  BIN_W / DEC_W / HEX_W  payload
- out_bin / out_dec / out_hex  out  BIN_W / DEC_W / HEX_W  applied stimulus, registered
- out_strobe  out  1  one-cycle pulse per applied record
- err_order  out  1  one-cycle pulse per dropped out-of-order record
- err_count  out  8  saturating count of dropped records
- now  out  TIME_W  current time counter
- busy  out  1  state == RUN
- done  out  1  level, state == DONE

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: now held at 0. Records are accepted (preload allowed). start → RUN.
  - RUN: now increments by 1 per cycle and saturates at all-ones. Records are accepted and applied. When last_seen and the FIFO is empty → DONE.
  - DONE: now frozen. start → RUN with now=0. This also clears last_seen, last_time, err_count and flushes the FIFO.
- Handshake: transfer occurs on a cycle with rec_valid && rec_ready.
  - rec_ready = !fifo_full && !last_seen.
  - rec_comment records are consumed but not written. rec_last still sets last_seen even on a comment.
- last_time register holds the timestamp of the last applied record; it is 0 after reset or start.
- Head evaluation, RUN only, at most one record per cycle:
  - head.time < last_time → pop; err_order pulse; err_count += 1 (saturates at 255); outputs unchanged.
  - last_time ≤ head.time ≤ now → pop; out_* ← head payload; out_strobe pulse; last_time ← head.time.
  - head.time > now → hold.
- Equal timestamps are legal. They apply on consecutive cycles, one strobe each, in FIFO order.
- A late but non-decreasing timestamp (now has passed it) is applied immediately, not flagged.
- A FIFO write and a pop may occur in the same cycle. Full plus pop does not raise rec_ready in that cycle.

## Timing
- Reset (rst_n low at an edge), effective at that edge:
  - state=IDLE, now=0, FIFO empty, last_seen=0, last_time=0.
  - out_bin/out_dec/out_hex=0, out_strobe=0, err_order=0, err_count=0, busy=0, done=0.
  - rec_ready=0 while rst_n is low; 1 on the first cycle after release.
- Reset mid-RUN discards all buffered records. No strobe is produced in the reset cycle.
- start sampled at edge E0 → now=0 in the cycle after E0, incrementing from there.
- Record accepted at edge N is at the FIFO head from cycle N+1.
- Apply latency: the decision is made in the cycle where head.time ≤ now. out_* and out_strobe are visible the following cycle, i.e. when now = T+1 for an on-time record.
- done rises the cycle after the final pop. busy falls in the same cycle.

## Structure
- Shared package or include pattern_sched_pkg holds:
  - state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the record-width localparam (TIME_W+BIN_W+DEC_W+HEX_W);
  - the err_count width.
- One sub-module: sync_fifo. It is a parameterized width/depth single-clock FIFO with synchronous active-low reset and flush, and full/empty flags. It is reusable by other fileio blocks.

## Test plan
- Preload records t=0, 5, 5, 9 in IDLE, then pulse start → out_strobe at now=1, 6, 7, 10 with matching payloads; done high the cycle after the 4th pop.
- Records t=10 then t=4 → t=10 is applied; t=4 causes an err_order pulse, err_count=1, and out_* keep the t=10 values.
- Stream 6 records into DEPTH=4 with no stall on the apply side → rec_ready low while full; no record lost or duplicated; order preserved.
- A comment record carrying rec_last between data records → comment is never applied; rec_ready goes low after it; done asserts once the FIFO drains.
- Assert rst_n low in RUN with 3 records buffered → next cycle all outputs are 0, state IDLE, rec_ready=1, and no further strobes.
- Push 300 out-of-order records → err_count saturates at 255.
